// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding
// select encodings, mult/div tracker states and a register-compare helper.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  // $zero is hardwired, so a dependency on it is never a real hazard.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/md_tracker.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM with a 4-bit down-counter that
// keeps MdBusy high for MD_LAT cycles after an issue.
module md_tracker
  import mips_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic MdStartE,
  output logic MdBusy
);

  localparam logic [3:0] RELOAD = 4'(MD_LAT - 1);

  md_state_t  state, state_next;
  logic [3:0] cnt, cnt_next;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      MD_IDLE: begin
        if (MdStartE) begin
          state_next = MD_BUSY;
          cnt_next   = RELOAD;
        end
      end
      MD_BUSY: begin
        // A re-issue while busy restarts the latency window.
        if (MdStartE) begin
          cnt_next = RELOAD;
        end else if (cnt == '0) begin
          state_next = MD_IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign MdBusy = (state == MD_BUSY);

  a_no_issue_while_busy: assert property (@(posedge CLK) disable iff (!rst_n)
    !(MdStartE && (state == MD_BUSY)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/ID forwarding selects, fetch/decode stall and
// ID/EX flush. Optional stall-cause performance counters under HAZ_PERF_EN.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             BranchD,
  input  logic             MdStartE,
  input  logic             MdUseD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0] LdStallCnt,
  output logic [CNT_W-1:0] BrStallCnt,
  output logic [CNT_W-1:0] MdStallCnt
`endif
);

  if (MD_LAT < 1 || MD_LAT > 15) begin : g_bad_md_lat
    $error("hazard_ctrl: MD_LAT must be in 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  logic ldstall, brstall, mdstall, stall;

  md_tracker #(.MD_LAT(MD_LAT)) u_md_tracker (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .MdStartE (MdStartE),
    .MdBusy   (MdBusy)
  );

  assign ldstall = MemToRegE && (reg_match(RtE, RsD) || reg_match(RtE, RtD));

  assign brstall = BranchD &&
                   ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                    (MemToRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));

  assign mdstall = MdUseD && (MdStartE || MdBusy);

  // Outputs are held inactive while reset is asserted.
  assign stall  = rst_n && (ldstall || brstall || mdstall);
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  assign ForwardAD = rst_n && RegWriteM && reg_match(WriteRegM, RsD);
  assign ForwardBD = rst_n && RegWriteM && reg_match(WriteRegM, RtD);

  always_comb begin
    ForwardAE = FWD_RF;
    if (rst_n) begin
      if (RegWriteM && reg_match(WriteRegM, RsE))      ForwardAE = FWD_MEM;
      else if (RegWriteW && reg_match(WriteRegW, RsE)) ForwardAE = FWD_WB;
    end
  end

  always_comb begin
    ForwardBE = FWD_RF;
    if (rst_n) begin
      if (RegWriteM && reg_match(WriteRegM, RtE))      ForwardBE = FWD_MEM;
      else if (RegWriteW && reg_match(WriteRegW, RtE)) ForwardBE = FWD_WB;
    end
  end

`ifdef HAZ_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      LdStallCnt <= '0;
      BrStallCnt <= '0;
      MdStallCnt <= '0;
    end else begin
      if (ldstall && LdStallCnt != '1) LdStallCnt <= LdStallCnt + CNT_ONE;
      if (brstall && BrStallCnt != '1) BrStallCnt <= BrStallCnt + CNT_ONE;
      if (mdstall && MdStallCnt != '1) MdStallCnt <= MdStallCnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MD_LAT=4, CNT_W=4); counter checks
// are compiled in when HAZ_PERF_EN is defined.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic       BranchD, MdStartE, MdUseD;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZ_PERF_EN
  logic [3:0] LdStallCnt, BrStallCnt, MdStallCnt;
`endif

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .BranchD(BranchD), .MdStartE(MdStartE), .MdUseD(MdUseD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy)
`ifdef HAZ_PERF_EN
    ,
    .LdStallCnt(LdStallCnt), .BrStallCnt(BrStallCnt), .MdStallCnt(MdStallCnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned rsd, rtd, rse, rte, wre, wrm, wrw;
    int unsigned rwe, rwm, rww, meme, memm, br, mduse;
    int unsigned stall, fae, fbe, fad, fbd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemToRegE = 1'b0; MemToRegM = 1'b0;
    BranchD = 1'b0; MdStartE = 1'b0; MdUseD = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, ".StallF"}, 32'(StallF), 32'(exp));
    chk({name, ".StallD"}, 32'(StallD), 32'(exp));
    chk({name, ".FlushE"}, 32'(FlushE), 32'(exp));
  endtask

  vec_t vt[16];

  initial begin
    vt[0]  = '{0,0,5,0,0,5,5, 0,1,1, 0,0,0,0, 0,2,0,0,0}; // MEM beats WB
    vt[1]  = '{0,0,5,0,0,5,5, 0,0,1, 0,0,0,0, 0,1,0,0,0}; // WB only
    vt[2]  = '{0,0,0,0,0,0,0, 1,1,1, 1,1,1,1, 0,0,0,0,0}; // all $zero
    vt[3]  = '{0,0,9,7,0,7,9, 0,1,1, 0,0,0,0, 0,1,2,0,0}; // A from WB, B from MEM
    vt[4]  = '{8,0,0,8,0,0,0, 0,0,0, 1,0,0,0, 1,0,0,0,0}; // load-use on Rs
    vt[5]  = '{1,8,0,8,0,0,0, 0,0,0, 1,0,0,0, 1,0,0,0,0}; // load-use on Rt
    vt[6]  = '{0,0,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0,0}; // load to $zero
    vt[7]  = '{8,0,0,8,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0}; // not a load
    vt[8]  = '{3,0,0,0,3,0,0, 1,0,0, 0,0,1,0, 1,0,0,0,0}; // branch on EX result
    vt[9]  = '{3,0,0,0,0,3,0, 0,1,0, 0,0,1,0, 0,0,0,1,0}; // branch forwards from MEM
    vt[10] = '{0,4,0,0,0,4,0, 0,1,0, 0,1,1,0, 1,0,0,0,1}; // branch on MEM load
    vt[11] = '{3,0,0,0,3,0,0, 1,0,0, 0,0,0,0, 0,0,0,0,0}; // no branch
    vt[12] = '{0,0,0,0,0,0,0, 0,0,0, 0,0,0,1, 0,0,0,0,0}; // HI/LO use, unit idle
    vt[13] = '{0,0,0,0,0,0,0, 1,0,0, 0,0,1,0, 0,0,0,0,0}; // branch vs $zero
    vt[14] = '{0,4,0,0,0,4,0, 0,0,0, 0,1,1,0, 1,0,0,0,0}; // MEM load, RegWriteM low
    vt[15] = '{3,0,0,0,3,0,0, 0,0,0, 0,0,1,0, 0,0,0,0,0}; // EX not writing

    clr_in();
    rst_n = 1'b0;
    RsE = 5'd8; RsD = 5'd8; RtE = 5'd8; WriteRegM = 5'd8;
    RegWriteM = 1'b1; MemToRegE = 1'b1;
    #3;
    chk_stall("reset", 1'b0);
    chk("reset.ForwardAE", 32'(ForwardAE), 32'd0);
    chk("reset.ForwardBE", 32'(ForwardBE), 32'd0);
    chk("reset.ForwardAD", 32'(ForwardAD), 32'd0);
    chk("reset.MdBusy", 32'(MdBusy), 32'd0);
`ifdef HAZ_PERF_EN
    chk("reset.LdStallCnt", 32'(LdStallCnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    clr_in();

    for (int i = 0; i < 16; i++) begin
      tick();
      RsD = 5'(vt[i].rsd); RtD = 5'(vt[i].rtd);
      RsE = 5'(vt[i].rse); RtE = 5'(vt[i].rte);
      WriteRegE = 5'(vt[i].wre); WriteRegM = 5'(vt[i].wrm); WriteRegW = 5'(vt[i].wrw);
      RegWriteE = 1'(vt[i].rwe); RegWriteM = 1'(vt[i].rwm); RegWriteW = 1'(vt[i].rww);
      MemToRegE = 1'(vt[i].meme); MemToRegM = 1'(vt[i].memm);
      BranchD = 1'(vt[i].br); MdUseD = 1'(vt[i].mduse);
      #1;
      chk_stall($sformatf("vec%0d", i), 1'(vt[i].stall));
      chk($sformatf("vec%0d.ForwardAE", i), 32'(ForwardAE), 32'(vt[i].fae));
      chk($sformatf("vec%0d.ForwardBE", i), 32'(ForwardBE), 32'(vt[i].fbe));
      chk($sformatf("vec%0d.ForwardAD", i), 32'(ForwardAD), 32'(vt[i].fad));
      chk($sformatf("vec%0d.ForwardBD", i), 32'(ForwardBD), 32'(vt[i].fbd));
    end

    // Load-use stall lasts one cycle once the load moves on.
    tick();
    clr_in();
    pulse_reset();
    MemToRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
    #1;
    chk_stall("ld.cyc0", 1'b1);
    tick();
    clr_in();
    #1;
    chk_stall("ld.cyc1", 1'b0);
`ifdef HAZ_PERF_EN
    chk("ld.LdStallCnt", 32'(LdStallCnt), 32'd1);
`endif

    // Mult/div stall window: StallD cycles 0..4, MdBusy cycles 1..4.
    tick();
    pulse_reset();
    MdUseD = 1'b1; MdStartE = 1'b1;
    #1;
    chk("md.cyc0.StallD", 32'(StallD), 32'd1);
    chk("md.cyc0.MdBusy", 32'(MdBusy), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      MdStartE = 1'b0;
      #1;
      chk($sformatf("md.cyc%0d.StallD", k), 32'(StallD), 32'(k <= 4));
      chk($sformatf("md.cyc%0d.MdBusy", k), 32'(MdBusy), 32'(k <= 4));
    end
`ifdef HAZ_PERF_EN
    chk("md.MdStallCnt", 32'(MdStallCnt), 32'd5);
`endif

    // Reset asserted in the middle of BUSY.
    clr_in();
    tick();
    MdUseD = 1'b1; MdStartE = 1'b1;
    tick();
    MdStartE = 1'b0;
    tick();
    #1;
    chk("rstmid.pre.MdBusy", 32'(MdBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.MdBusy", 32'(MdBusy), 32'd0);
    chk("rstmid.StallD", 32'(StallD), 32'd0);
`ifdef HAZ_PERF_EN
    chk("rstmid.MdStallCnt", 32'(MdStallCnt), 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    #1;
    chk("rstmid.rel.MdBusy", 32'(MdBusy), 32'd0);
    chk("rstmid.rel.StallD", 32'(StallD), 32'd0);
    tick();
    #1;
    chk("rstmid.idle.MdBusy", 32'(MdBusy), 32'd0);
    chk("rstmid.idle.StallD", 32'(StallD), 32'd0);

`ifdef HAZ_PERF_EN
    // Independent causes, then saturation at 4'hF.
    clr_in();
    pulse_reset();
    MemToRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8;
    for (int k = 0; k < 3; k++) tick();
    chk("both.LdStallCnt", 32'(LdStallCnt), 32'd3);
    chk("both.BrStallCnt", 32'(BrStallCnt), 32'd3);
    BranchD = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    chk("sat.LdStallCnt", 32'(LdStallCnt), 32'd15);
    chk("sat.BrStallCnt", 32'(BrStallCnt), 32'd3);
    chk("sat.MdStallCnt", 32'(MdStallCnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Computes EX-stage and decode-stage (branch comparator) forwarding selects. Generates the fetch/decode stall and the ID/EX flush. The flush drives the CLR input of the ID/EX pipeline register. Also owns a small FSM that tracks occupancy of the multi-cycle mult/div unit and holds dependent HI/LO instructions in decode until the result is ready.

## Interface
- MD_LAT, 4: mult/div busy cycles after issue; legal range 1..15.
- CNT_W, 32: width of performance counters (only used with HAZ_PERF_EN).

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RsD, RtD  in  5  source registers of the instruction in decode.
- RsE, RtE  in  5  source registers of the instruction in execute.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage.
- MemToRegE, MemToRegM  in  1  load flag per stage.
- BranchD  in  1  branch in decode, resolved in decode.
- MdStartE  in  1  mult/div issuing in execute this cycle.
- MdUseD  in  1  decode instruction reads HI/LO or is itself a mult/div.
- StallF, StallD  out  1  hold PC and IF/ID.
- FlushE  out  1  clear ID/EX; inserts a bubble.
- ForwardAD, ForwardBD  out  1  decode comparator operand from the MEM result.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- MdBusy  out  1  mult/div unit occupied.
- LdStallCnt, BrStallCnt, MdStallCnt  out  CNT_W  performance counters (HAZ_PERF_EN only).

## Operation
- Register 0 never matches in any forwarding or hazard compare.
- ForwardAE:
  - 10 if RegWriteM and WriteRegM==RsE.
  - Otherwise 01 if RegWriteW and WriteRegW==RsE.
  - Otherwise 00.
  - MEM has priority over WB.
  - ForwardBE is identical, using RtE.
- ForwardAD = RegWriteM and WriteRegM==RsD. ForwardBD is identical, using RtD.
- ldstall = MemToRegE and (RtE==RsD or RtE==RtD).
- brstall = BranchD and one of:
  - RegWriteE and WriteRegE matches RsD or RtD.
  - MemToRegM and WriteRegM matches RsD or RtD.
- mdstall = MdUseD and (MdStartE or MdBusy).
- StallF = StallD = FlushE = ldstall or brstall or mdstall.
- Mult/div FSM:
  - States: IDLE and BUSY, plus a 4-bit down-counter.
  - IDLE: on a clock edge with MdStartE=1, go to BUSY and load cnt=MD_LAT-1.
  - BUSY: decrement cnt each edge. When cnt==0, go to IDLE.
  - MdBusy = (state==BUSY).
  - MdStartE=1 while in BUSY reloads cnt=MD_LAT-1 and stays in BUSY. This is a protocol violation, since mdstall prevents it, and is flagged by an assertion in simulation.
- FlushE does not cancel the mult/div in execute: that instruction is valid in the cycle FlushE rises.

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and FSM state, and valid in the same cycle.
- FSM and counters update on the rising CLK edge.
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, MdBusy=0, all counters 0.
  - StallF, StallD, FlushE, ForwardAD/BD are forced 0; ForwardAE/BE are forced 00.
- Mult/div stall length: with MdUseD held and MdStartE at cycle 0, StallD is high for cycles 0..MD_LAT (MD_LAT+1 cycles) and low at cycle MD_LAT+1.
- Reset mid-BUSY: the FSM returns to IDLE immediately and the stall drops the same cycle.
- Simultaneous stall causes: outputs are OR'd; each performance counter evaluates its own cause independently.

## Configuration
- HAZ_PERF_EN defined:
  - LdStallCnt, BrStallCnt and MdStallCnt are present.
  - Each increments on every clock edge where its cause is 1.
  - Each saturates at all-ones and is cleared only by reset.
- HAZ_PERF_EN undefined: the counter ports and logic are omitted entirely.

## Structure
- The shared package mips_pkg holds:
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The md_state_t enum (MD_IDLE, MD_BUSY).
- Sub-module md_tracker contains the FSM and down-counter. Its ports are CLK, rst_n, MdStartE and MdBusy, and it takes parameter MD_LAT.
- Forwarding, stall logic and performance counters stay in hazard_ctrl.

## Test plan
- EX forwarding: RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 -> ForwardAE=10. With RegWriteM=0 -> ForwardAE=01. With RsE=0 and all writes to reg 0 -> ForwardAE=00.
- Load-use: MemToRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for exactly 1 cycle. LdStallCnt (HAZ_PERF_EN) = 1.
- Branch hazards:
  - BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> stall.
  - Next cycle with MemToRegM=0, WriteRegM=3, RegWriteM=1 -> no stall, ForwardAD=1.
- Mult/div: MD_LAT=4, MdStartE pulse at cycle 0 with MdUseD=1 held -> StallD high cycles 0-4, MdBusy high cycles 1-4, StallD low at cycle 5.
- Reset mid-operation: rst_n low at cycle 2 of BUSY -> MdBusy=0, StallD=0 and counters 0 asynchronously. After release, FSM in IDLE.
- Counter saturation: CNT_W=4 with ldstall held 20 cycles -> LdStallCnt stops at 15.
